// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: streams program bytes from a byte-wide memory
// into a small circular queue and presents whole 1..3-byte instructions.
module instr_prefetch #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] memAddr,
  output logic       memStrobe,
  input  logic [7:0] memDataRead,
  output logic       outValid,
  input  logic       outReady,
  output logic [7:0] outInstr,
  output logic [7:0] outSecond,
  output logic [7:0] outThird,
  output logic [1:0] outLength,
  output logic [7:0] outPc,
  input  logic       redirect,
  input  logic [7:0] redirectPc
);
  // Output handshake: an instruction transfers on every rising edge where
  // outValid & outReady; while outValid & !outReady all out* hold stable,
  // and outValid never drops without a transfer (except reset/redirect).

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  function automatic logic [1:0] instr_len(input logic [7:0] op);
    logic [1:0] len;
    case (op[3:0])
      4'hE, 4'hF:                   len = 2'd1;
      4'h4, 4'h5, 4'h6, 4'h7, 4'hD: len = 2'd3;
      default:                      len = 2'd2;
    endcase
    return len;
  endfunction

  logic [7:0]    fpc_q, fpc_d;
  logic          in_flight_q;
  logic [7:0]    q_mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    qpc_q, qpc_d;

  logic       out_valid_q;
  logic [7:0] out_instr_q, out_second_q, out_third_q, out_pc_q;
  logic [1:0] out_len_q;

  logic       push, strobe, load;
  logic [7:0] win [3];
  logic [1:0] head_len;
  logic [CW:0] avail;

  // The byte arriving from memory is visible as if already queued, so an
  // instruction completed by it can load the output in the same cycle.
  always_comb begin
    push  = in_flight_q & ~redirect;
    avail = {1'b0, count_q} + {{CW{1'b0}}, push};
    for (int i = 0; i < 3; i++) begin
      if ((CW+1)'(i) < {1'b0, count_q}) win[i] = q_mem_q[head_q + PW'(i)];
      else                              win[i] = memDataRead;
    end
    head_len = instr_len(win[0]);
    load     = ~redirect
             & (avail >= {{(CW-1){1'b0}}, head_len})
             & (~out_valid_q | outReady);
    strobe   = ~reset & ~redirect
             & (({1'b0, count_q} + {{CW{1'b0}}, in_flight_q}) < DEPTH_C);

    fpc_d   = strobe ? fpc_q + 8'd1 : fpc_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    head_d  = load ? head_q + PW'(head_len) : head_q;
    qpc_d   = load ? qpc_q + {6'd0, head_len} : qpc_q;
    count_d = count_q + CW'(push) - (load ? CW'(head_len) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q        <= RESET_PC;
      qpc_q        <= RESET_PC;
      in_flight_q  <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= 8'h00;
      out_second_q <= 8'h00;
      out_third_q  <= 8'h00;
      out_len_q    <= 2'd0;
      out_pc_q     <= 8'h00;
    end else if (redirect) begin
      fpc_q       <= redirectPc;
      qpc_q       <= redirectPc;
      in_flight_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      qpc_q       <= qpc_d;
      in_flight_q <= strobe;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      if (load) begin
        out_valid_q  <= 1'b1;
        out_instr_q  <= win[0];
        out_second_q <= (head_len >= 2'd2) ? win[1] : 8'h00;
        out_third_q  <= (head_len == 2'd3) ? win[2] : 8'h00;
        out_len_q    <= head_len;
        out_pc_q     <= qpc_q;
      end else if (outReady) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (!reset && push) q_mem_q[tail_q] <= memDataRead;
  end

  assign memAddr   = fpc_q;
  assign memStrobe = strobe;
  assign outValid  = out_valid_q;
  assign outInstr  = out_instr_q;
  assign outSecond = out_second_q;
  assign outThird  = out_third_q;
  assign outLength = out_len_q;
  assign outPc     = out_pc_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: memory model, scoreboard of expected
// instructions, and directed phases for latency, hold, throughput, redirect, wrap.
module tb_instr_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, memStrobe, outValid, outReady, redirect;
  logic [7:0] memAddr, memDataRead, outInstr, outSecond, outThird, outPc, redirectPc;
  logic [1:0] outLength;

  logic       fe_reset, fe_memStrobe, fe_outValid, fe_outReady, fe_redirect;
  logic [7:0] fe_memAddr, fe_memDataRead, fe_outInstr, fe_outSecond, fe_outThird;
  logic [7:0] fe_outPc, fe_redirectPc;
  logic [1:0] fe_outLength;

  instr_prefetch #(.DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .reset(reset), .memAddr(memAddr), .memStrobe(memStrobe),
    .memDataRead(memDataRead), .outValid(outValid), .outReady(outReady),
    .outInstr(outInstr), .outSecond(outSecond), .outThird(outThird),
    .outLength(outLength), .outPc(outPc), .redirect(redirect),
    .redirectPc(redirectPc)
  );

  instr_prefetch #(.DEPTH(4), .RESET_PC(8'hFE)) u_dut_fe (
    .clk(clk), .reset(fe_reset), .memAddr(fe_memAddr), .memStrobe(fe_memStrobe),
    .memDataRead(fe_memDataRead), .outValid(fe_outValid), .outReady(fe_outReady),
    .outInstr(fe_outInstr), .outSecond(fe_outSecond), .outThird(fe_outThird),
    .outLength(fe_outLength), .outPc(fe_outPc), .redirect(fe_redirect),
    .redirectPc(fe_redirectPc)
  );

  // Memory model: one-cycle read latency, garbage when not strobed.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    memDataRead    <= memStrobe ? mem[memAddr] : 8'($urandom);
    fe_memDataRead <= fe_memStrobe ? mem[fe_memAddr] : 8'($urandom);
  end

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  function automatic logic [33:0] pack_out(input logic [7:0] pc, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [1:0] len);
    return {pc, b0, b1, b2, len};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Sample the current cycle's handshake, then advance to the next negedge.
  task automatic cycle();
    logic [33:0] got;
    if (!reset && outValid && outReady) begin
      got = pack_out(outPc, outInstr, outSecond, outThird, outLength);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed %h expected none", got);
      end else begin
        chk("sb_out", got, exp_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic load_prog_a();
    logic [7:0] prog [6];
    prog = '{8'hFF, 8'h0C, 8'h55, 8'h06, 8'h03, 8'h10};
    for (int i = 0; i < 6; i++) mem[i] = prog[i];
  endtask

  task automatic push_prog_a();
    exp_q.push_back(pack_out(8'h00, 8'hFF, 8'h00, 8'h00, 2'd1));
    exp_q.push_back(pack_out(8'h01, 8'h0C, 8'h55, 8'h00, 2'd2));
    exp_q.push_back(pack_out(8'h03, 8'h06, 8'h03, 8'h10, 2'd3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirectPc = 8'h00; outReady = 1'b0;
    fe_reset = 1'b1; fe_redirect = 1'b0; fe_redirectPc = 8'h00; fe_outReady = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    load_prog_a();
    @(negedge clk);
    repeat (3) cycle();

    // Reset state
    chk("rst_valid", 34'(outValid), 34'd0);
    chk("rst_strobe", 34'(memStrobe), 34'd0);
    chk("rst_addr", 34'(memAddr), 34'h00);
    chk("rst_fields", pack_out(outPc, outInstr, outSecond, outThird, outLength), 34'd0);

    // Phase A: basic stream with ready high, latency from release
    push_prog_a();
    outReady = 1'b1;
    reset    = 1'b0;
    #1 chk("a_first_strobe", 34'({memStrobe, memAddr}), 34'({1'b1, 8'h00}));
    cycle();
    chk("a_lat_c2", 34'(outValid), 34'd0);
    cycle();
    chk("a_lat_c3", 34'(outValid), 34'd1);
    wait_drain(30);
    outReady = 1'b0;

    // Phase B: consumer stalls 10 cycles, queue fills, then drains intact
    do_reset();
    push_prog_a();
    reset = 1'b0;
    cycle();
    cycle();
    chk("b_valid_c3", 34'(outValid), 34'd1);
    for (int i = 0; i < 9; i++) begin
      chk("b_hold", pack_out(outPc, outInstr, outSecond, outThird, outLength),
          pack_out(8'h00, 8'hFF, 8'h00, 8'h00, 2'd1));
      cycle();
    end
    chk("b_hold_valid", 34'(outValid), 34'd1);
    chk("b_full_strobe", 34'(memStrobe), 34'd0);
    chk("b_full_addr", 34'(memAddr), 34'h05);
    outReady = 1'b1;
    wait_drain(30);
    outReady = 1'b0;

    // Phase C: run of 1-byte opcodes, one instruction per cycle
    for (int i = 0; i < 6; i++) mem[i] = 8'hFF;
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(pack_out(8'(i), 8'hFF, 8'h00, 8'h00, 2'd1));
    outReady = 1'b1;
    reset    = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("c_throughput_valid", 34'(outValid), 34'd1);
    end
    cycle();
    outReady = 1'b0;
    chk("c_sb_empty", 34'(exp_q.size()), 34'd0);

    // Phase D: redirect while a fetch response arrives and a transfer completes
    load_prog_a();
    mem[8'h40] = 8'h0C;
    mem[8'h41] = 8'hAA;
    do_reset();
    exp_q.push_back(pack_out(8'h00, 8'hFF, 8'h00, 8'h00, 2'd1));
    exp_q.push_back(pack_out(8'h01, 8'h0C, 8'h55, 8'h00, 2'd2));
    exp_q.push_back(pack_out(8'h40, 8'h0C, 8'hAA, 8'h00, 2'd2));
    outReady = 1'b1;
    reset    = 1'b0;
    repeat (4) cycle();
    redirect   = 1'b1;
    redirectPc = 8'h40;
    #1 chk("d_no_strobe_n", 34'(memStrobe), 34'd0);
    cycle();
    redirect = 1'b0;
    #1 chk("d_strobe_n1", 34'({memStrobe, memAddr}), 34'({1'b1, 8'h40}));
    chk("d_valid_n1", 34'(outValid), 34'd0);
    cycle();
    chk("d_valid_n2", 34'(outValid), 34'd0);
    cycle();
    chk("d_valid_n3", 34'(outValid), 34'd0);
    cycle();
    chk("d_valid_n4", 34'(outValid), 34'd1);
    cycle();
    outReady = 1'b0;
    chk("d_sb_empty", 34'(exp_q.size()), 34'd0);

    // Phase E: RESET_PC = FE, instruction wraps through FF..00
    mem[8'hFE] = 8'h0C;
    mem[8'hFF] = 8'h77;
    fe_reset = 1'b0;
    cycle();
    chk("e_addr_c2", 34'(fe_memAddr), 34'hFF);
    cycle();
    chk("e_addr_wrap", 34'(fe_memAddr), 34'h00);
    chk("e_valid_c3", 34'(fe_outValid), 34'd0);
    cycle();
    chk("e_valid_c4", 34'(fe_outValid), 34'd1);
    chk("e_wrap_out", pack_out(fe_outPc, fe_outInstr, fe_outSecond, fe_outThird, fe_outLength),
        pack_out(8'hFE, 8'h0C, 8'h77, 8'h00, 2'd2));

    // Phase F: reset asserted mid-stream with an instruction held
    do_reset();
    reset = 1'b0;
    cycle();
    cycle();
    chk("f_valid_before", 34'(outValid), 34'd1);
    reset = 1'b1;
    #1 chk("f_strobe_in_rst", 34'(memStrobe), 34'd0);
    cycle();
    chk("f_valid_after", 34'(outValid), 34'd0);
    chk("f_strobe_after", 34'(memStrobe), 34'd0);
    chk("f_fields_after", pack_out(outPc, outInstr, outSecond, outThird, outLength), 34'd0);
    exp_q.push_back(pack_out(8'h00, 8'hFF, 8'h00, 8'h00, 2'd1));
    reset    = 1'b0;
    outReady = 1'b1;
    #1 chk("f_restart", 34'({memStrobe, memAddr}), 34'({1'b1, 8'h00}));
    cycle();
    cycle();
    chk("f_valid_c3", 34'(outValid), 34'd1);
    cycle();
    outReady = 1'b0;
    chk("f_sb_empty", 34'(exp_q.size()), 34'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
